// File: rtl/alu_control_mc_pkg.sv
// Shared encodings for the multicycle ALU-control decoder: funct codes,
// alu_op classes, ALU control codes, FSM states and the decoded payload.
package alu_control_mc_pkg;

  localparam int unsigned FUNCT_W    = 6;
  localparam int unsigned ALU_CODE_W = 4;

  localparam int unsigned OP_MEM = 0;
  localparam int unsigned OP_BEQ = 1;
  localparam int unsigned OP_RTY = 2;
  localparam int unsigned OP_ORI = 3;

  localparam logic [FUNCT_W-1:0] F_ADD  = 6'b100000;
  localparam logic [FUNCT_W-1:0] F_SUB  = 6'b100010;
  localparam logic [FUNCT_W-1:0] F_AND  = 6'b100100;
  localparam logic [FUNCT_W-1:0] F_OR   = 6'b100101;
  localparam logic [FUNCT_W-1:0] F_NOR  = 6'b100111;
  localparam logic [FUNCT_W-1:0] F_SLT  = 6'b101010;
  localparam logic [FUNCT_W-1:0] F_SLL  = 6'b000000;
  localparam logic [FUNCT_W-1:0] F_SRL  = 6'b000010;
  localparam logic [FUNCT_W-1:0] F_MULT = 6'b011000;
  localparam logic [FUNCT_W-1:0] F_DIV  = 6'b011010;

  localparam logic [ALU_CODE_W-1:0] ALU_AND  = 4'b0000;
  localparam logic [ALU_CODE_W-1:0] ALU_OR   = 4'b0001;
  localparam logic [ALU_CODE_W-1:0] ALU_ADD  = 4'b0010;
  localparam logic [ALU_CODE_W-1:0] ALU_SUB  = 4'b0110;
  localparam logic [ALU_CODE_W-1:0] ALU_SLT  = 4'b0111;
  localparam logic [ALU_CODE_W-1:0] ALU_SLL  = 4'b1000;
  localparam logic [ALU_CODE_W-1:0] ALU_SRL  = 4'b1001;
  localparam logic [ALU_CODE_W-1:0] ALU_MULT = 4'b1010;
  localparam logic [ALU_CODE_W-1:0] ALU_DIV  = 4'b1011;
  localparam logic [ALU_CODE_W-1:0] ALU_NOR  = 4'b1100;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MC   = 1'b1
  } state_e;

  typedef struct packed {
    logic [ALU_CODE_W-1:0] ctrl;
    logic                  multi;
    logic                  illegal;
  } dec_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/alu_control_mc_decode.sv
// Combinational alu_op/funct decode into ALU control code plus multi/illegal flags.
module alu_control_mc_decode
  import alu_control_mc_pkg::*;
#(
  parameter int unsigned OP_W = 4
) (
  input  logic [OP_W-1:0]    alu_op,
  input  logic [FUNCT_W-1:0] funct,
  output dec_t               dec_c
);

  always_comb begin
    dec_c = '0;
    if (alu_op == OP_W'(OP_MEM)) begin
      dec_c.ctrl = ALU_ADD;
    end else if (alu_op == OP_W'(OP_BEQ)) begin
      dec_c.ctrl = ALU_SUB;
    end else if (alu_op == OP_W'(OP_ORI)) begin
      dec_c.ctrl = ALU_OR;
    end else if (alu_op == OP_W'(OP_RTY)) begin
      case (funct)
        F_ADD:   dec_c.ctrl = ALU_ADD;
        F_SUB:   dec_c.ctrl = ALU_SUB;
        F_AND:   dec_c.ctrl = ALU_AND;
        F_OR:    dec_c.ctrl = ALU_OR;
        F_NOR:   dec_c.ctrl = ALU_NOR;
        F_SLT:   dec_c.ctrl = ALU_SLT;
        F_SLL:   dec_c.ctrl = ALU_SLL;
        F_SRL:   dec_c.ctrl = ALU_SRL;
        F_MULT: begin
          dec_c.ctrl  = ALU_MULT;
          dec_c.multi = 1'b1;
        end
        F_DIV: begin
          dec_c.ctrl  = ALU_DIV;
          dec_c.multi = 1'b1;
        end
        default: dec_c.illegal = 1'b1;
      endcase
    end else begin
      dec_c.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/alu_control_mc.sv
// Registered, handshaked ALU-control decoder; MULT/DIV results are held back
// by a down-counter so out_valid appears N cycles after acceptance.
module alu_control_mc
  import alu_control_mc_pkg::*;
#(
  parameter int unsigned OP_W        = 4,
  parameter int unsigned CTRL_W      = 4,
  parameter int unsigned MULT_CYCLES = 4,
  parameter int unsigned DIV_CYCLES  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OP_W-1:0]    alu_op,
  input  logic [FUNCT_W-1:0] funct,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CTRL_W-1:0]  alu_ctrl,
  output logic               multi,
  output logic               illegal,
  output logic               busy
);

  localparam int unsigned CNT_W = $clog2(max_u(MULT_CYCLES, DIV_CYCLES) + 1);
  localparam logic [CNT_W-1:0] MULT_N = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_N  = CNT_W'(DIV_CYCLES);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  out_valid_q, out_valid_d;
  logic                  busy_q, busy_d;
  logic [ALU_CODE_W-1:0] alu_ctrl_q, alu_ctrl_d;
  logic                  multi_q, multi_d;
  logic                  illegal_q, illegal_d;

  dec_t             dec_c;
  logic             accept_c;
  logic [CNT_W-1:0] n_sel_c;

  alu_control_mc_decode #(.OP_W(OP_W)) u_decode (
    .alu_op (alu_op),
    .funct  (funct),
    .dec_c  (dec_c)
  );

  assign in_ready = (state_q == ST_IDLE) && (!out_valid_q || out_ready) && !flush;
  assign accept_c = in_valid && in_ready;
  assign n_sel_c  = (dec_c.ctrl == ALU_DIV) ? DIV_N : MULT_N;

  // Next-state: flush wins; otherwise drain handshake, then accept or count down.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    alu_ctrl_d  = alu_ctrl_q;
    multi_d     = multi_q;
    illegal_d   = illegal_q;
    if (flush) begin
      state_d     = ST_IDLE;
      count_d     = '0;
      out_valid_d = 1'b0;
      busy_d      = 1'b0;
    end else begin
      if (out_valid_q && out_ready) out_valid_d = 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept_c) begin
            alu_ctrl_d = dec_c.ctrl;
            multi_d    = dec_c.multi;
            illegal_d  = dec_c.illegal;
            // N==1 multicycle ops complete like single-cycle ones.
            if (dec_c.multi && (n_sel_c > CNT_W'(1))) begin
              state_d     = ST_MC;
              busy_d      = 1'b1;
              count_d     = n_sel_c - CNT_W'(1);
              out_valid_d = 1'b0;
            end else begin
              out_valid_d = 1'b1;
            end
          end
        end
        ST_MC: begin
          count_d = count_q - CNT_W'(1);
          if (count_q == CNT_W'(1)) begin
            state_d     = ST_IDLE;
            busy_d      = 1'b0;
            out_valid_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      alu_ctrl_q  <= '0;
      multi_q     <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      alu_ctrl_q  <= alu_ctrl_d;
      multi_q     <= multi_d;
      illegal_q   <= illegal_d;
    end
  end

  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign alu_ctrl  = CTRL_W'(alu_ctrl_q);
  assign multi     = multi_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_control_mc.sv
// Scoreboard bench for alu_control_mc: stimulus pushes expected results with
// their handshake cycle; a negedge monitor pops and compares.
module tb_alu_control_mc;

  logic       clk = 1'b0;
  logic       rst, flush, in_valid, out_ready;
  logic [3:0] alu_op;
  logic [5:0] funct;
  logic       in_ready, out_valid, multi, illegal, busy;
  logic [3:0] alu_ctrl;

  alu_control_mc dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_op    (alu_op),
    .funct     (funct),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_ctrl  (alu_ctrl),
    .multi     (multi),
    .illegal   (illegal),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [3:0] ctrl;
    logic       multi;
    logic       ill;
    int         at;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [5:0] fn, input logic [3:0] ec,
                       input logic em, input logic ei, input int lat, input bit push);
    alu_op   = op;
    funct    = fn;
    in_valid = 1'b1;
    #1;
    chk("in_ready_at_issue", 32'(in_ready), 1);
    if (push) sb.push_back('{ec, em, ei, cyc + lat});
    tick();
    in_valid = 1'b0;
  endtask

  // Monitor: every handshake must match the oldest pending expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output: ctrl=%b multi=%b illegal=%b at cycle %0d", alu_ctrl, multi, illegal, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if ({alu_ctrl, multi, illegal} !== {e.ctrl, e.multi, e.ill} || cyc != e.at) begin
          n_fail++;
          $display("FAIL result: got ctrl=%b multi=%b illegal=%b cycle=%0d, expected ctrl=%b multi=%b illegal=%b cycle=%0d",
                   alu_ctrl, multi, illegal, cyc, e.ctrl, e.multi, e.ill, e.at);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    alu_op = '0; funct = '0;
    repeat (2) tick();
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_multi", 32'(multi), 0);
    chk("rst_illegal", 32'(illegal), 0);
    chk("rst_alu_ctrl", 32'(alu_ctrl), 0);
    rst = 1'b0;
    out_ready = 1'b1;
    tick();

    // R-type ADD, then a stream of mem/beq/ori
    issue(4'd2, 6'b100000, 4'b0010, 1'b0, 1'b0, 1, 1'b1);
    issue(4'd0, 6'b111111, 4'b0010, 1'b0, 1'b0, 1, 1'b1);
    issue(4'd1, 6'b000000, 4'b0110, 1'b0, 1'b0, 1, 1'b1);
    issue(4'd3, 6'b011000, 4'b0001, 1'b0, 1'b0, 1, 1'b1);
    // remaining R-type functs back to back
    issue(4'd2, 6'b100010, 4'b0110, 1'b0, 1'b0, 1, 1'b1);
    issue(4'd2, 6'b100100, 4'b0000, 1'b0, 1'b0, 1, 1'b1);
    issue(4'd2, 6'b100101, 4'b0001, 1'b0, 1'b0, 1, 1'b1);
    issue(4'd2, 6'b100111, 4'b1100, 1'b0, 1'b0, 1, 1'b1);
    issue(4'd2, 6'b000000, 4'b1000, 1'b0, 1'b0, 1, 1'b1);
    issue(4'd2, 6'b000010, 4'b1001, 1'b0, 1'b0, 1, 1'b1);
    tick();

    // stall on SLT with a competing request pending
    out_ready = 1'b0;
    issue(4'd2, 6'b101010, 4'b0111, 1'b0, 1'b0, 4, 1'b1);
    alu_op = 4'd2; funct = 6'b100000; in_valid = 1'b1;
    repeat (3) begin
      #1;
      chk("stall_out_valid", 32'(out_valid), 1);
      chk("stall_alu_ctrl", 32'(alu_ctrl), 32'h7);
      chk("stall_in_ready", 32'(in_ready), 0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("handshake_in_ready", 32'(in_ready), 1);
    sb.push_back('{4'b0010, 1'b0, 1'b0, cyc + 1});
    tick();
    in_valid = 1'b0;
    tick();

    // DIV: 32-cycle latency
    issue(4'd2, 6'b011010, 4'b1011, 1'b1, 1'b0, 32, 1'b1);
    for (int i = 0; i < 31; i++) begin
      chk("div_busy", 32'(busy), 1);
      chk("div_in_ready", 32'(in_ready), 0);
      chk("div_out_valid", 32'(out_valid), 0);
      tick();
    end
    chk("div_done_busy", 32'(busy), 0);
    chk("div_done_valid", 32'(out_valid), 1);
    tick();

    // MULT: 4-cycle latency
    issue(4'd2, 6'b011000, 4'b1010, 1'b1, 1'b0, 4, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("mult_busy", 32'(busy), 1);
      chk("mult_out_valid", 32'(out_valid), 0);
      tick();
    end
    chk("mult_done_busy", 32'(busy), 0);
    chk("mult_done_valid", 32'(out_valid), 1);
    tick();

    // illegal funct and illegal alu_op
    issue(4'd2, 6'b111111, 4'b0000, 1'b0, 1'b1, 1, 1'b1);
    issue(4'd7, 6'b100000, 4'b0000, 1'b0, 1'b1, 1, 1'b1);
    #1;
    chk("illegal_busy", 32'(busy), 0);
    tick();

    // flush a DIV when count has reached 10
    issue(4'd2, 6'b011010, 4'b1011, 1'b1, 1'b0, 32, 1'b0);
    repeat (21) tick();
    flush = 1'b1;
    #1;
    chk("flush_in_ready", 32'(in_ready), 0);
    tick();
    flush = 1'b0;
    #1;
    chk("flush_busy", 32'(busy), 0);
    chk("flush_out_valid", 32'(out_valid), 0);
    chk("flush_in_ready_after", 32'(in_ready), 1);
    chk("flush_keeps_ctrl", 32'(alu_ctrl), 32'hB);
    chk("flush_keeps_multi", 32'(multi), 1);
    repeat (40) tick();
    chk("flush_no_late_output", 32'(out_valid), 0);

    // async reset mid-MULT
    issue(4'd2, 6'b011000, 4'b1010, 1'b1, 1'b0, 4, 1'b0);
    chk("mult_busy_before_rst", 32'(busy), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_out_valid", 32'(out_valid), 0);
    chk("arst_multi", 32'(multi), 0);
    chk("arst_illegal", 32'(illegal), 0);
    chk("arst_alu_ctrl", 32'(alu_ctrl), 0);
    tick();
    rst = 1'b0;
    tick();
    issue(4'd2, 6'b101010, 4'b0111, 1'b0, 1'b0, 1, 1'b1);
    repeat (10) tick();
    chk("scoreboard_drained", 32'(sb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
